truth_table_sweeper: RTL and testbench

- Sequential test-driver stage that sits directly around the 4-input/3-output combinational logic block (Circuit_2).
- Upstream role: on a start pulse it drives all 16 input vectors ABCD = 0000..1111 in ascending order into the block.
- Downstream role: after a settle period it samples the block's three outputs for each vector and packs them into a 48-bit result word.
- Used for on-board self-check and in the bench, in place of hand-read truth tables.

---
 rtl/truth_table_sweeper_pkg.sv | 21 ++
 rtl/truth_table_sweeper_if.sv | 28 ++
 rtl/truth_table_sweeper_sweep_settle_timer.sv | 28 ++
 rtl/truth_table_sweeper.sv | 125 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper: FSM encoding,
// vector/result geometry and the result slot position helper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 16;
  localparam int IN_BITS     = 4;
  localparam int OUT_BITS    = 3;
  localparam int RESULT_W    = NUM_VECTORS * OUT_BITS;

  function automatic int SLOT_LSB(input int i);
    return OUT_BITS * i;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper (master) and the logic block / host (slave).
// Compare ports exist only when TRUTH_TABLE_SWEEPER_CHECK_EN is defined.
interface truth_table_sweeper_if;
  import truth_table_sweeper_pkg::*;

  logic                start;
  logic                A, B, C, D;
  logic                Out_1, Out_2, Out_3;
  logic                busy;
  logic                done;
  logic [RESULT_W-1:0] result;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  logic [RESULT_W-1:0] expected;
  logic                mismatch;
  logic [IN_BITS-1:0]  fail_idx;

  modport master (input  start, Out_1, Out_2, Out_3, expected,
                  output A, B, C, D, busy, done, result, mismatch, fail_idx);
  modport slave  (output start, Out_1, Out_2, Out_3, expected,
                  input  A, B, C, D, busy, done, result, mismatch, fail_idx);
`else
  modport master (input  start, Out_1, Out_2, Out_3,
                  output A, B, C, D, busy, done, result);
  modport slave  (output start, Out_1, Out_2, Out_3,
                  input  A, B, C, D, busy, done, result);
`endif

endinterface

// File: rtl/truth_table_sweeper_sweep_settle_timer.sv
// Loadable down-counter: after load, expired rises once SETTLE_CYCLES-1
// further cycles have elapsed, giving a SETTLE_CYCLES-cycle hold.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign expired = (r_cnt == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives ABCD = 0..15 into the logic block and packs its three outputs per
// vector into result. TRUTH_TABLE_SWEEPER_CHECK_EN adds an expected-value compare.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                   clk,
  input logic                   reset,
  truth_table_sweeper_if.master bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] DRIVE  = ST_DRIVE;
  localparam logic [1:0] SAMPLE = ST_SAMPLE;
  localparam logic [1:0] DONE   = ST_DONE;
  localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(NUM_VECTORS - 1);

  logic [1:0]          r_state;
  logic [IN_BITS-1:0]  r_idx;
  logic [IN_BITS-1:0]  r_vec;
  logic                r_busy;
  logic                r_done;
  logic [RESULT_W-1:0] r_result;

  logic                w_start_ok;
  logic                w_load;
  logic                w_expired;
  logic [OUT_BITS-1:0] w_slot;

  assign w_start_ok = (r_state == IDLE) && bus.start;
  assign w_load     = w_start_ok || ((r_state == SAMPLE) && (r_idx != LAST_IDX));
  assign w_slot     = {bus.Out_1, bus.Out_2, bus.Out_3};

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_vec    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= DRIVE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b1;
          end
        end
        DRIVE: begin
          if (w_expired) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_result[SLOT_LSB(int'(r_idx)) +: OUT_BITS] <= w_slot;
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= DRIVE;
            r_idx   <= r_idx + 1'b1;
            r_vec   <= r_idx + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_vec   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.A      = r_vec[3];
  assign bus.B      = r_vec[2];
  assign bus.C      = r_vec[1];
  assign bus.D      = r_vec[0];
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  logic [RESULT_W-1:0] r_expected;
  logic                r_mismatch;
  logic [IN_BITS-1:0]  r_fail_idx;

  // Only the first differing slot is recorded; later ones leave fail_idx alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_expected <= '0;
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_start_ok) begin
      r_expected <= bus.expected;
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
    end else if ((r_state == SAMPLE) && !r_mismatch &&
                 (w_slot != r_expected[SLOT_LSB(int'(r_idx)) +: OUT_BITS])) begin
      r_mismatch <= 1'b1;
      r_fail_idx <= r_idx;
    end
  end

  assign bus.mismatch = r_mismatch;
  assign bus.fail_idx = r_fail_idx;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two DUTs (SETTLE_CYCLES 1 and 3) each wrapped
// around a table-driven model of the logic block; compare tests need CHECK_EN.
module tb_truth_table_sweeper;

  localparam logic [47:0] CIRCUIT_2 = 48'h6B82_6069_02F0;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  truth_table_sweeper_if bus1 ();
  truth_table_sweeper_if bus3 ();

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  truth_table_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logic block models: output triple {Out_1,Out_2,Out_3} for vector v is tbl[3v+2:3v].
  logic [47:0] tt1, tt3;
  logic        g3;
  logic [2:0]  rnd3;
  logic [3:0]  v1, v3;
  logic [2:0]  o1, o3;

  assign v1 = {bus1.A, bus1.B, bus1.C, bus1.D};
  assign v3 = {bus3.A, bus3.B, bus3.C, bus3.D};
  assign o1 = tt1[int'(v1)*3 +: 3];
  assign o3 = g3 ? rnd3 : tt3[int'(v3)*3 +: 3];
  assign {bus1.Out_1, bus1.Out_2, bus1.Out_3} = o1;
  assign {bus3.Out_1, bus3.Out_2, bus3.Out_3} = o3;

  function automatic logic [2:0] block_out(input logic [47:0] tbl, input int v);
    return tbl[3*v +: 3];
  endfunction

  function automatic logic [47:0] ref_result(input logic [47:0] tbl);
    logic [47:0] r;
    logic [2:0]  o;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      o = block_out(tbl, i);
      r[3*i+2] = o[2];
      r[3*i+1] = o[1];
      r[3*i]   = o[0];
    end
    return r;
  endfunction

  // Pulses start, then watches ncyc edges after the edge that sampled it.
  // Position k = edges since that sample edge; vector k/(S+1) is on ABCD while k < 16(S+1).
  task automatic do_sweep(input int sel, input int ncyc, input int pa, input int pb,
                          output int done_at, output int done_cnt, output int vec_err);
    int per;
    logic d, b;
    logic [3:0] v;
    per = (sel == 3) ? 4 : 2;
    done_at = -1; done_cnt = 0; vec_err = 0;
    @(negedge clk);
    if (sel == 3) bus3.start = 1'b1; else bus1.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= ncyc; k++) begin
      if (sel == 3) begin
        g3 = (((k-1) % per) != per-1) && ((k-1) < 16*per);
        rnd3 = 3'($urandom);
        bus3.start = ((k-1) == pa) || ((k-1) == pb);
      end else begin
        bus1.start = ((k-1) == pa) || ((k-1) == pb);
      end
      @(posedge clk); #1;
      d = (sel == 3) ? bus3.done : bus1.done;
      b = (sel == 3) ? bus3.busy : bus1.busy;
      v = (sel == 3) ? v3 : v1;
      if (d) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < 16*per) begin
        if (v != 4'(k / per)) vec_err++;
        if (!b) vec_err++;
      end else if (k == 16*per + 1) begin
        if (v != 4'd0 || b) vec_err++;
      end
    end
    g3 = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    n_total++; if (bus1.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus1.busy); else n_pass++;
    n_total++; if (bus1.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus1.done); else n_pass++;
    n_total++; if (bus1.result !== 48'd0) $display("FAIL reset_result got %h want 0", bus1.result); else n_pass++;
    n_total++; if (v1 !== 4'd0) $display("FAIL reset_abcd got %b want 0000", v1); else n_pass++;
    n_total++; if (bus3.result !== 48'd0 || bus3.busy !== 1'b0) $display("FAIL reset_dut3 got %h/%b want 0/0", bus3.result, bus3.busy); else n_pass++;
  endtask

  task automatic test_default_sweep();
    int da, dc, ve;
    tt1 = CIRCUIT_2;
    do_sweep(1, 40, -1, -1, da, dc, ve);
    n_total++; if (da !== 32) $display("FAIL dflt_done_pos got %0d want 32", da); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL dflt_done_count got %0d want 1", dc); else n_pass++;
    n_total++; if (ve !== 0) $display("FAIL dflt_vec_busy_errs got %0d want 0", ve); else n_pass++;
    n_total++; if (bus1.result !== ref_result(tt1)) $display("FAIL dflt_result got %h want %h", bus1.result, ref_result(tt1)); else n_pass++;
    n_total++; if (bus1.result !== 48'h6B82_6069_02F0) $display("FAIL dflt_result_const got %h want 6b826069 02f0", bus1.result); else n_pass++;
    n_total++; if (bus1.result[5:3] !== 3'b110) $display("FAIL dflt_slot1 got %b want 110", bus1.result[5:3]); else n_pass++;
    n_total++; if (bus1.result[41:39] !== 3'b111) $display("FAIL dflt_slot13 got %b want 111", bus1.result[41:39]); else n_pass++;
  endtask

  task automatic test_timing_variant();
    int da, dc, ve;
    tt3 = CIRCUIT_2;
    do_sweep(3, 72, -1, -1, da, dc, ve);
    n_total++; if (da !== 64) $display("FAIL s3_done_pos got %0d want 64", da); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL s3_done_count got %0d want 1", dc); else n_pass++;
    n_total++; if (ve !== 0) $display("FAIL s3_vec_hold_errs got %0d want 0", ve); else n_pass++;
    n_total++; if (bus3.result !== ref_result(tt3)) $display("FAIL s3_result got %h want %h", bus3.result, ref_result(tt3)); else n_pass++;
  endtask

  task automatic test_ignored_start();
    int da, dc, ve;
    tt1 = CIRCUIT_2;
    do_sweep(1, 40, 5, 20, da, dc, ve);
    n_total++; if (da !== 32) $display("FAIL ign_done_pos got %0d want 32", da); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL ign_done_count got %0d want 1", dc); else n_pass++;
    n_total++; if (ve !== 0) $display("FAIL ign_vec_busy_errs got %0d want 0", ve); else n_pass++;
  endtask

  task automatic test_start_held();
    int q[$];
    int first, second;
    tt1 = CIRCUIT_2;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk); #1;
      if (bus1.done) begin
        q.push_back(k);
        if (q.size() == 2) bus1.start = 1'b0;
      end
    end
    bus1.start = 1'b0;
    first  = (q.size() > 0) ? q[0] : -1;
    second = (q.size() > 1) ? q[1] : -1;
    n_total++; if (q.size() !== 2) $display("FAIL held_done_count got %0d want 2", q.size()); else n_pass++;
    n_total++; if (first !== 32 || second !== 66) $display("FAIL held_done_pos got %0d,%0d want 32,66", first, second); else n_pass++;
  endtask

  task automatic test_random_tables();
    int da, dc, ve;
    logic [47:0] want;
    for (int it = 0; it < 4; it++) begin
      tt1 = {16'($urandom), $urandom};
      want = ref_result(tt1);
      do_sweep(1, 36, -1, -1, da, dc, ve);
      n_total++; if (bus1.result !== want || da !== 32) $display("FAIL rand_result[%0d] got %h@%0d want %h@32", it, bus1.result, da, want); else n_pass++;
      tt1 = ~tt1;
      repeat (5) @(posedge clk); #1;
      n_total++; if (bus1.result !== want) $display("FAIL rand_hold[%0d] got %h want %h", it, bus1.result, want); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int da, dc, ve;
    tt1 = CIRCUIT_2;
    @(negedge clk); bus1.start = 1'b1;
    @(posedge clk); #1; bus1.start = 1'b0;
    repeat (12) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_total++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) $display("FAIL mid_rst_ctrl got busy=%b done=%b want 0/0", bus1.busy, bus1.done); else n_pass++;
    n_total++; if (bus1.result !== 48'd0) $display("FAIL mid_rst_result got %h want 0", bus1.result); else n_pass++;
    n_total++; if (v1 !== 4'd0) $display("FAIL mid_rst_abcd got %b want 0000", v1); else n_pass++;
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    do_sweep(1, 36, -1, -1, da, dc, ve);
    n_total++; if (bus1.result !== 48'h6B82_6069_02F0 || da !== 32) $display("FAIL mid_rst_resweep got %h@%0d want 6b82606902f0@32", bus1.result, da); else n_pass++;
  endtask

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
  task automatic test_check_feature();
    int da, dc, ve;
    int j1, j2;
    logic [47:0] e;
    tt1 = CIRCUIT_2;
    bus1.expected = CIRCUIT_2;
    do_sweep(1, 34, -1, -1, da, dc, ve);
    n_total++; if (bus1.mismatch !== 1'b0) $display("FAIL chk_match got mismatch=%b want 0", bus1.mismatch); else n_pass++;
    bus1.expected = CIRCUIT_2 & ~(48'h7 << 27);
    do_sweep(1, 34, -1, -1, da, dc, ve);
    n_total++; if (bus1.mismatch !== 1'b1 || bus1.fail_idx !== 4'd9) $display("FAIL chk_slot9 got %b/%0d want 1/9", bus1.mismatch, bus1.fail_idx); else n_pass++;
    j1 = $urandom_range(0, 7);
    j2 = $urandom_range(8, 15);
    e = CIRCUIT_2 ^ (48'h1 << (3*j1 + $urandom_range(0, 2))) ^ (48'h1 << (3*j2 + $urandom_range(0, 2)));
    bus1.expected = e;
    do_sweep(1, 34, -1, -1, da, dc, ve);
    n_total++; if (bus1.mismatch !== 1'b1 || bus1.fail_idx !== 4'(j1)) $display("FAIL chk_first got %b/%0d want 1/%0d", bus1.mismatch, bus1.fail_idx, j1); else n_pass++;
    bus1.expected = CIRCUIT_2;
    do_sweep(1, 34, -1, -1, da, dc, ve);
    n_total++; if (bus1.mismatch !== 1'b0 || bus1.fail_idx !== 4'd0) $display("FAIL chk_clear got %b/%0d want 0/0", bus1.mismatch, bus1.fail_idx); else n_pass++;
  endtask
`endif

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    g3 = 1'b0;
    rnd3 = 3'd0;
    tt1 = CIRCUIT_2;
    tt3 = CIRCUIT_2;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    bus1.expected = '0;
    bus3.expected = '0;
`endif
    test_reset();
    test_default_sweep();
    test_timing_variant();
    test_ignored_start();
    test_start_held();
    test_random_tables();
    test_reset_mid();
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    test_check_feature();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
